alu_arbiter_32bit: RTL

- Shares one `alu_32bit` datapath between two requesters.
- Round-robin arbitration accepts one operation at a time and latches its operands.
- Drives the ALU `start` level for a programmable settle time, then captures result and N/Z/C/V flags into a response register.
- Returns the response over a valid/ready channel tagged with the requester id; sits between the two command sources and the ALU instance.

---
 rtl/alu_arbiter_32bit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_32bit.sv
// Two-requester round-robin front end for a shared 32-bit ALU: latches one command,
// holds alu_start for SETTLE_CYCLES, then presents a tagged response over valid/ready.
module alu_arbiter_32bit #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_op,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_alu_start;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic [31:0] r_rsp_result;
  logic [3:0]  r_rsp_flags;

  logic [1:0]  w_valid;
  logic [1:0]  w_ready;
  logic [31:0] w_a [2];
  logic [31:0] w_b [2];
  logic [3:0]  w_op [2];
  logic        w_idle;
  logic        w_grant_id;
  logic        w_accept;
  logic [3:0]  w_sel_op;
  logic        w_op_legal;
  logic        w_settle_done;

  assign w_valid = {req1_valid, req0_valid};
  assign w_a[0]  = req0_a;
  assign w_a[1]  = req1_a;
  assign w_b[0]  = req0_b;
  assign w_b[1]  = req1_b;
  assign w_op[0] = req0_op;
  assign w_op[1] = req1_op;

  assign w_idle = (r_state == S_IDLE);

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    w_grant_id = w_valid[1];
    if (w_valid == 2'b11) begin
      w_grant_id = ~r_last_grant;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_idle && w_valid[gi] && (w_grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign w_accept   = |w_ready;

  assign w_sel_op      = w_op[w_grant_id];
  assign w_op_legal    = (w_sel_op >= 4'd1) && (w_sel_op <= 4'd9);
  assign w_settle_done = (r_cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_alu_start  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_a[w_grant_id];
            r_alu_b      <= w_b[w_grant_id];
            r_alu_op     <= w_sel_op;
            r_rsp_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cnt        <= '0;
            if (w_op_legal) begin
              r_state     <= S_ISSUE;
              r_alu_start <= 1'b1;
            end else begin
              // Illegal opcodes bypass the ALU and answer immediately.
              r_state      <= S_RESPOND;
              r_rsp_valid  <= 1'b1;
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (w_settle_done) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
            r_rsp_err    <= 1'b0;
            r_alu_start  <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = {28'd0, r_alu_op};
  assign alu_start  = r_alu_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_err    = r_rsp_err;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign busy       = (r_state != S_IDLE);

endmodule
